// File: rtl/samp_capture.sv
// Decimating fixed-length record capture: samples the ADC stream every DECIM
// cycles after a Samp_en rising edge, buffers NUM_SAMP points and streams them out.
module samp_capture #(
    parameter int DW       = 16,
    parameter int AW       = 10,
    parameter int DECIM    = 400,
    parameter int NUM_SAMP = 1024
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Samp_en,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [15:0]   samp_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    localparam int             DCW       = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [15:0]    LAST      = 16'(NUM_SAMP);
    localparam logic [DCW-1:0] DECIM_MAX = DCW'(DECIM - 1);

    state_t          state_q;
    logic            se_q;
    logic            low_seen_q;
    logic [DCW-1:0]  decim_q, decim_d;
    logic [15:0]     samp_cnt_q, samp_cnt_d;
    logic            overflow_q;
    logic            done_q;
    logic            dout_valid_q;
    logic [DW-1:0]   dout_q;
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic [DW-1:0]   mem_q [0:(1<<AW)-1];

    logic start, take, fifo_empty, fifo_full, out_adv, pop, push, drained;

    // A level still high when reset releases is not an edge: require a low first.
    assign start      = Samp_en && !se_q && low_seen_q;
    assign take       = (state_q == S_CAPTURE) && (decim_q == '0);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign out_adv    = !dout_valid_q || dout_ready;
    assign pop        = !fifo_empty && out_adv;
    assign push       = take && (!fifo_full || pop);
    assign drained    = fifo_empty && out_adv;

    always_comb begin
        decim_d    = (decim_q == DECIM_MAX) ? '0 : decim_q + 1'b1;
        samp_cnt_d = (samp_cnt_q == LAST) ? samp_cnt_q : samp_cnt_q + 16'd1;
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= S_IDLE;
            se_q         <= 1'b0;
            low_seen_q   <= 1'b0;
            decim_q      <= '0;
            samp_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            se_q <= Samp_en;
            if (!Samp_en) begin
                low_seen_q <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // Output register refills whenever it is empty or being consumed.
            if (out_adv) begin
                dout_valid_q <= !fifo_empty;
                if (!fifo_empty) begin
                    dout_q <= mem_q[rd_ptr_q[AW-1:0]];
                end
            end

            case (state_q)
                S_IDLE: begin
                    samp_cnt_q <= '0;
                    overflow_q <= 1'b0;
                    done_q     <= 1'b0;
                    decim_q    <= '0;
                    if (start) begin
                        state_q <= S_ARM;
                    end
                end
                S_ARM: begin
                    decim_q <= '0;
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    decim_q <= decim_d;
                    if (take) begin
                        samp_cnt_q <= samp_cnt_d;
                        if (!push) begin
                            overflow_q <= 1'b1;
                        end
                        if (samp_cnt_d == LAST) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_q    <= S_ARM;
                        done_q     <= 1'b0;
                        overflow_q <= 1'b0;
                        samp_cnt_q <= '0;
                        decim_q    <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q == S_ARM) || (state_q == S_CAPTURE) ||
                        !fifo_empty || dout_valid_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign samp_cnt   = samp_cnt_q;

endmodule

// File: tb/tb_samp_capture.sv
// Bench for samp_capture: queue-based record model checked every cycle, plus
// directed scenarios with hand-computed cycle/value expectations.
module tb_samp_capture;

    localparam int DW       = 16;
    localparam int AW       = 2;
    localparam int DECIM    = 4;
    localparam int NUM_SAMP = 8;
    localparam int DEPTH    = 4;

    logic          Clk, Rst, Samp_en, dout_ready;
    logic [DW-1:0] data_in, dout;
    logic          dout_valid, busy, done, overflow;
    logic [15:0]   samp_cnt;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int ready_mode = 0;
    int got[$];

    samp_capture #(.DW(DW), .AW(AW), .DECIM(DECIM), .NUM_SAMP(NUM_SAMP)) dut (
        .Clk(Clk), .Rst(Rst), .Samp_en(Samp_en), .data_in(data_in),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .done(done), .overflow(overflow), .samp_cnt(samp_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: a record is a set of take cycles; held words form one queue whose
    // head is presented two cycles after capture at the earliest.
    int  m_cyc = 0, m_start = 0, m_taken = 0, m_occ = 0;
    bit  m_active = 0, m_done = 0, m_ovf = 0, m_prev_en = 1;
    bit  m_vld, m_acc, m_pop, m_take;
    int  qv[$], qa[$];

    always @(negedge Clk) begin
        if (Rst) begin
            qv.delete(); qa.delete();
            m_active = 0; m_done = 0; m_ovf = 0; m_taken = 0; m_prev_en = 1;
        end else begin
            m_vld = (qv.size() > 0) && (qa[0] + 2 <= m_cyc);
            chk("dout_valid", dout_valid, m_vld);
            if (m_vld) chk("dout", dout, qv[0]);
            chk("busy", busy, (m_active && m_taken < NUM_SAMP && m_cyc > m_start) || qv.size() > 0);
            chk("done", done, m_done);
            chk("overflow", overflow, m_ovf);
            chk("samp_cnt", samp_cnt, m_taken);
            if (dout_valid && dout_ready) got.push_back(int'(dout));

            m_acc  = m_vld && dout_ready;
            m_occ  = qv.size() - (m_vld ? 1 : 0);
            m_pop  = (m_occ > 0) && (!m_vld || dout_ready);
            m_take = m_active && m_taken < NUM_SAMP && m_cyc == m_start + 2 + m_taken * DECIM;
            if (m_acc) begin
                void'(qv.pop_front()); void'(qa.pop_front());
            end
            if (m_take) begin
                if (m_occ < DEPTH || m_pop) begin
                    qv.push_back(int'(data_in)); qa.push_back(m_cyc);
                end else begin
                    m_ovf = 1;
                end
                m_taken++;
            end
            if (Samp_en && !m_prev_en && (!m_active || m_done)) begin
                m_active = 1; m_start = m_cyc; m_taken = 0; m_ovf = 0; m_done = 0;
            end else if (m_active && m_taken == NUM_SAMP && qv.size() == 0) begin
                m_done = 1;
            end
            m_prev_en = Samp_en;
        end
        m_cyc++;
    end

    task automatic step();
        @(posedge Clk);
        cyc++;
        #1;
        data_in = 16'(cyc);
        case (ready_mode)
            0: dout_ready = 1'b1;
            1: dout_ready = 1'b0;
            default: dout_ready = (cyc % 2 == 1);
        endcase
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic new_epoch();
        Samp_en = 1'b0;
        repeat (4) step();
        cyc = 0;
        data_in = '0;
        got.delete();
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && done !== 1'b1; i++) step();
        chk(name, done, 1);
    endtask

    task automatic chk_seq(input string name, input int first, input int n);
        chk({name, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++)
            chk({name, "_word"}, (i < got.size()) ? got[i] : 32'hFFFF_FFFF, first + DECIM * i);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_dout"}, dout, 0);
        chk({name, "_dout_valid"}, dout_valid, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_overflow"}, overflow, 0);
        chk({name, "_samp_cnt"}, samp_cnt, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        Rst = 1'b0; Samp_en = 1'b0; dout_ready = 1'b1; data_in = '0;
        #1 Rst = 1'b1;
        #1 chk_zero("reset");
        repeat (3) step();
        Rst = 1'b0;

        // Basic record, consumer always ready
        ready_mode = 0;
        new_epoch();
        goto(10); Samp_en = 1'b1;
        goto(11); chk("t1_arm_busy", busy, 1);
        goto(12); chk("t1_cnt12", samp_cnt, 0);
        goto(13); chk("t1_cnt13", samp_cnt, 1);
        goto(14); chk("t1_valid14", dout_valid, 1); chk("t1_dout14", dout, 12);
        goto(41); chk("t1_cnt41", samp_cnt, 8);
        goto(42); chk("t1_done42", done, 0);
        goto(43); chk("t1_done43", done, 1); chk("t1_ovf", overflow, 0); chk("t1_busy43", busy, 0);
        chk_seq("t1_seq", 12, 8);

        // Stall hold with ready toggling
        ready_mode = 2;
        new_epoch();
        goto(10); Samp_en = 1'b1;
        goto(14); chk("t3_dout14", dout, 12); chk("t3_ready14", dout_ready, 0);
        goto(15); chk("t3_hold_valid", dout_valid, 1); chk("t3_hold_dout", dout, 12);
        wait_done("t3_done", 200);
        chk_seq("t3_seq", 12, 8);

        // Edge during capture is ignored
        ready_mode = 0;
        new_epoch();
        goto(10); Samp_en = 1'b1;
        goto(20); Samp_en = 1'b0;
        goto(21); Samp_en = 1'b1;
        goto(23); chk("t6_cnt23", samp_cnt, 3); chk("t6_busy23", busy, 1);
        wait_done("t6_done", 200);
        chk("t6_done_cycle", cyc, 43);
        chk("t6_cnt", samp_cnt, 8);
        chk_seq("t6_seq", 12, 8);

        // Backpressure: output stage plus 4 FIFO words hold, later takes drop
        ready_mode = 1;
        new_epoch();
        goto(10); Samp_en = 1'b1;
        goto(14); chk("t2_dout14", dout, 12);
        goto(32); chk("t2_ovf32", overflow, 0);
        goto(33); chk("t2_ovf33", overflow, 1);
        goto(41); chk("t2_cnt41", samp_cnt, 8); chk("t2_done41", done, 0); chk("t2_busy41", busy, 1);
        goto(49); ready_mode = 0;
        goto(54); chk("t2_done54", done, 0);
        goto(55); chk("t2_done55", done, 1); chk("t2_ovf55", overflow, 1); chk("t2_cnt55", samp_cnt, 8);
        chk_seq("t2_seq", 12, 5);

        // Re-arm from DONE clears sticky status
        new_epoch();
        chk("t5_done_held", done, 1); chk("t5_ovf_held", overflow, 1);
        goto(10); Samp_en = 1'b1;
        chk("t5_ovf10", overflow, 1);
        goto(11); chk("t5_done_arm", done, 0); chk("t5_ovf_arm", overflow, 0);
        chk("t5_cnt_arm", samp_cnt, 0); chk("t5_busy_arm", busy, 1);
        wait_done("t5_done", 200);
        chk("t5_done_cycle", cyc, 43);
        chk("t5_ovf_end", overflow, 0);
        chk_seq("t5_seq", 12, 8);

        // Asynchronous reset mid-capture
        new_epoch();
        goto(10); Samp_en = 1'b1;
        goto(25);
        #2 Rst = 1'b1;
        #1 chk_zero("t4_async");
        step();
        Rst = 1'b0;
        got.delete();
        goto(45); chk("t4_no_rec_busy", busy, 0); chk("t4_no_rec_cnt", samp_cnt, 0);
        chk("t4_no_rec_valid", dout_valid, 0);
        goto(46); Samp_en = 1'b0;
        goto(50); Samp_en = 1'b1;
        goto(52); chk("t4_busy52", busy, 1); chk("t4_cnt52", samp_cnt, 0);
        wait_done("t4_done", 200);
        chk("t4_done_cycle", cyc, 83);
        chk_seq("t4_seq", 52, 8);

        repeat (3) step();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
